johnson_rx_checker: RTL
=======================

Name: johnson_rx_checker

Overview:
- Receiving end of a Johnson (twisted-ring) count stream: samples an N-bit Johnson code each valid cycle and decodes it to a binary phase index 0..2N-1.
- Checks code legality and step-by-step succession, and acquires/holds lock on the sequence.
- Sits downstream of any Johnson counter output (phase generators, ring sequencers) as decoder plus integrity monitor.

Parameters:
- N, 4, Johnson register width; sequence length 2N.
- LOCK_CNT, 3, consecutive legal successor codes needed to declare lock (1..15).
- ERRW, 8, width of the saturating error counter.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- in_valid  input  1  in_code is sampled this cycle
- in_code  input  N  Johnson code, bit N-1 = first stage (MSB)
- clear_err  input  1  synchronous clear of err_count
- idx_out  output  $clog2(2N)  decoded phase index
- idx_valid  output  1  idx_out updated from a legal code
- code_err  output  1  pulse: sampled code not a legal Johnson word
- seq_err  output  1  pulse: legal code but not successor of previous, while locked
- locked  output  1  sequence lock indicator
- err_count  output  ERRW  saturating count of code_err plus seq_err events

Behaviour:
- Reset (reset=1 at a clock edge): idx_out=0, idx_valid=0, code_err=0, seq_err=0, locked=0, err_count=0, FSM=HUNT, expected index=0. Reset mid-stream discards all history.
- Legal codes: MSB=1 with k leading ones followed by zeros (k=1..N), giving index k. MSB=0 with j leading zeros followed by ones (j=1..N-1), giving index 2N-popcount. All-zero gives index 0. Everything else is illegal.
- Successor: (prev+1) mod 2N; index 2N-1 wraps to 0.
- Latency: one cycle. Outputs registered at the edge after the sample; code_err, seq_err and idx_valid are single-cycle pulses.
- in_valid=0: no state change, pulses deassert, idx_out holds.
- Legal sample: idx_out=index, idx_valid=1. Illegal sample: idx_valid=0, idx_out holds, code_err=1.
- FSM states:
  - HUNT:
    - legal -> ACQ, good=0, prev=index
    - illegal -> stay HUNT
  - ACQ:
    - legal successor -> good+1, prev=index; when good reaches LOCK_CNT -> LOCKED
    - legal non-successor -> good=0, prev=index, stay ACQ
    - illegal -> HUNT
  - LOCKED:
    - legal successor -> stay
    - legal non-successor -> seq_err=1, prev=index, stay LOCKED
    - illegal -> code_err=1, go to HUNT
- locked=1 exactly while FSM=LOCKED; registered, so it asserts on the cycle the LOCK_CNT-th successor is reflected in outputs.
- seq_err is flagged only in LOCKED. code_err is flagged in any state.
- err_count:
  - increments by 1 per cycle in which code_err or seq_err is set (never both in one cycle); saturates at 2^ERRW-1.
  - clear_err sets it to 0; if an error occurs in the same cycle as clear_err, the result is 1.
- Decode is pure combinational on the sampled code. All outputs are flops; no combinational path from inputs to outputs.

Decomposition:
- Package johnson_pkg:
  - FSM enum {HUNT, ACQ, LOCKED}
  - function for index width ($clog2(2N))
  - successor/wrap helper constant (2N-1)
- Sub-module johnson_decode: combinational; in_code -> legal, index. Reusable by any Johnson consumer.
- Top module holds the FSM, counters and output registers.

Test Plan (N=4, LOCK_CNT=3):
- Reset, then feed 0000,1000,1100,1110,1111 valid each cycle -> idx_out 0,1,2,3,4 one cycle later; locked rises with idx_out=3; no errors.
- Locked, continue 0111,0011,0001,0000 -> idx 5,6,7,0 (wrap); locked stays 1, err_count=0.
- Locked at idx 2, inject 1111 (skip) -> seq_err pulse, idx_out=4, locked=1, err_count=1; next 0111 accepted without error.
- Locked, inject 1010 -> code_err pulse, idx_valid=0, idx_out holds, locked=0, err_count+1; three further legal successors needed to relock.
- in_valid low for 5 cycles mid-sequence, then resume with the successor -> no errors, idx_out held during the gap; assert reset mid-stream -> all outputs 0 next cycle.
- ERRW=2: force 5 code errors -> err_count saturates at 3; clear_err together with an error -> err_count=1.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared types and sizing helpers for Johnson (twisted-ring) code consumers.
package johnson_pkg;

  typedef enum logic [1:0] {
    HUNT,
    ACQ,
    LOCKED
  } state_e;

  // Bits needed to hold a phase index 0..2N-1.
  function automatic int idx_width(input int n);
    return $clog2(2 * n);
  endfunction

  // Last phase index before the sequence wraps back to 0.
  function automatic int wrap_max(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson decoder: legality check plus phase index.
// A legal word has at most one transition between adjacent bits.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              code,
  output logic                      legal,
  output logic [idx_width(N)-1:0]   index
);

  localparam int IW = idx_width(N);

  logic [IW-1:0] ones;
  logic [IW-1:0] edges;

  always_comb begin
    ones  = '0;
    edges = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + IW'(code[i]);
    end
    for (int i = 0; i < N - 1; i++) begin
      edges = edges + IW'(code[i] ^ code[i+1]);
    end
    legal = (edges <= IW'(1));
    // Ones-led words fill phases 1..N; zeros-led words drain phases N+1..2N-1.
    if (code[N-1]) begin
      index = ones;
    end else if (ones == '0) begin
      index = '0;
    end else begin
      index = IW'(wrap_max(N)) - ones + IW'(1);
    end
  end

endmodule

// File: rtl/johnson_rx_checker.sv
// Johnson stream receiver: decodes each valid sample, checks succession,
// tracks lock and counts errors. All outputs registered, one cycle latency.
module johnson_rx_checker
  import johnson_pkg::*;
#(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERRW     = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [N-1:0]            in_code,
  input  logic                    clear_err,
  output logic [idx_width(N)-1:0] idx_out,
  output logic                    idx_valid,
  output logic                    code_err,
  output logic                    seq_err,
  output logic                    locked,
  output logic [ERRW-1:0]         err_count
);

  localparam int            IW   = idx_width(N);
  localparam logic [IW-1:0] LAST = IW'(wrap_max(N));

  state_e          state_q, state_d;
  logic [IW-1:0]   prev_q, prev_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [3:0]      good_q, good_d;
  logic            idx_valid_q, idx_valid_d;
  logic            code_err_q, code_err_d;
  logic            seq_err_q, seq_err_d;
  logic [ERRW-1:0] err_q, err_d;

  logic            dec_legal;
  logic [IW-1:0]   dec_idx;
  logic [IW-1:0]   succ_idx;
  logic            is_succ;
  logic            err_event;

  johnson_decode #(.N(N)) u_decode (
    .code  (in_code),
    .legal (dec_legal),
    .index (dec_idx)
  );

  assign succ_idx = (prev_q == LAST) ? '0 : prev_q + IW'(1);
  assign is_succ  = (dec_idx == succ_idx);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    idx_d       = idx_q;
    good_d      = good_q;
    idx_valid_d = 1'b0;
    code_err_d  = 1'b0;
    seq_err_d   = 1'b0;

    if (in_valid) begin
      if (!dec_legal) begin
        code_err_d = 1'b1;
        state_d    = HUNT;
      end else begin
        idx_d       = dec_idx;
        idx_valid_d = 1'b1;
        prev_d      = dec_idx;
        unique case (state_q)
          HUNT: begin
            state_d = ACQ;
            good_d  = '0;
          end
          ACQ: begin
            if (is_succ) begin
              good_d = good_q + 4'd1;
              if (good_d == 4'(LOCK_CNT)) state_d = LOCKED;
            end else begin
              good_d = '0;
            end
          end
          LOCKED: begin
            seq_err_d = !is_succ;
          end
          default: state_d = HUNT;
        endcase
      end
    end

    // Clear wins over history, but an error landing on the clear still counts.
    err_event = code_err_d | seq_err_d;
    err_d     = err_q;
    if (clear_err) begin
      err_d = err_event ? ERRW'(1) : '0;
    end else if (err_event && !(&err_q)) begin
      err_d = err_q + ERRW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= HUNT;
      prev_q      <= '0;
      idx_q       <= '0;
      good_q      <= '0;
      idx_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      idx_q       <= idx_d;
      good_q      <= good_d;
      idx_valid_q <= idx_valid_d;
      code_err_q  <= code_err_d;
      seq_err_q   <= seq_err_d;
      err_q       <= err_d;
    end
  end

  assign idx_out   = idx_q;
  assign idx_valid = idx_valid_q;
  assign code_err  = code_err_q;
  assign seq_err   = seq_err_q;
  assign locked    = (state_q == LOCKED);
  assign err_count = err_q;

endmodule
